btn_start_stop_ctrl: RTL and testbench
======================================

BTN_START_STOP_CTRL -- requirements
Module: btn_start_stop_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, giving consecutive stable samples needed to accept a button level change; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port btn_start, input, 1 bit, raw asynchronous start push-button, active-high.
REQ-005 The block SHALL have port btn_stop, input, 1 bit, raw asynchronous stop push-button, active-high.
REQ-006 The block SHALL have port start, output, 1 bit, registered single-cycle start command pulse to the downstream counter stage.
REQ-007 The block SHALL have port stop, output, 1 bit, registered single-cycle stop command pulse to the downstream counter stage.
REQ-008 The block SHALL have port running, output, 1 bit, registered level, 1 while the FSM is in RUN.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic uses it.
REQ-010 Each button SHALL have a debouncer with a 16-bit counter and a stable-level register.
REQ-011 Debouncer: if s2 == stable, counter SHALL clear to 0.
REQ-012 Debouncer: if s2 != stable and counter < DB_CYCLES-1, counter SHALL increment by 1.
REQ-013 Debouncer: if s2 != stable and counter == DB_CYCLES-1, stable SHALL load s2 and counter SHALL clear.
REQ-014 Debouncer result: stable changes only after DB_CYCLES consecutive differing s2 samples; any glitch shorter than that SHALL be filtered.
REQ-015 A press event SHALL be a 0->1 transition of a debounced stable level, detected against a one-cycle-delayed copy.
REQ-016 Release (1->0) events SHALL produce no output.
REQ-017 Latency: with raw input held high from before edge 0 and DB_CYCLES=D, stable SHALL rise at edge D+1 and the pulse SHALL be high from edge D+2 to edge D+3.
REQ-018 FSM states SHALL be IDLE and RUN.
REQ-019 IDLE + start press event SHALL cause start=1 for one cycle and a move to RUN on the same edge.
REQ-020 RUN + stop press event SHALL cause stop=1 for one cycle and a move to IDLE on the same edge.
REQ-021 Start press in RUN and stop press in IDLE SHALL be ignored: no pulse, no state change.
REQ-022 Simultaneous start and stop press events SHALL resolve as: in IDLE start wins, in RUN stop wins.
REQ-023 start and stop SHALL never be high in the same cycle, and each SHALL never be high for two consecutive cycles.
REQ-024 A button held indefinitely SHALL produce exactly one press event per debounced 0->1 transition.

Reset
REQ-025 reset=0 SHALL immediately clear synchronizers, counters, stable levels, delayed copies and start/stop, set running=0, and force the FSM to IDLE, with no clock required.
REQ-026 Reset asserted mid-debounce or in RUN SHALL discard all progress.
REQ-027 A button still held when reset deasserts SHALL be treated as a fresh press, producing a pulse D+2 edges after the first clock edge following release.

Verification
REQ-028 D=4, btn_start raised from 0 before edge 0 and held -> start=1 only between edges 6 and 7; running=1 from edge 6.
REQ-029 In RUN, btn_stop glitches high for 3 cycles at D=4 -> no stop pulse; running stays 1.
REQ-030 In RUN, btn_stop held 10 cycles -> exactly one stop pulse 6 edges after its rise; running=0 thereafter; a later btn_stop press in IDLE -> no pulse.
REQ-031 In IDLE, btn_start and btn_stop rise together and are held -> start pulse only, running=1; same stimulus in RUN -> stop pulse only, running=0.
REQ-032 Reset asserted at counter=2 during a start debounce while btn_start stays high -> outputs 0 at once; after release, start pulse at the 6th edge after the first post-reset edge.
REQ-033 Bouncy stimulus (1,0,1,1,0,1,1,1,1 per cycle) at D=4 -> exactly one start pulse, 2 edges after the fourth consecutive 1 reaches s2.

Source files
------------

// File: rtl/btn_start_stop_ctrl.sv
// Start/stop push-button controller.
// Two raw buttons are synchronized, debounced and edge-detected. The
// resulting press events drive a two-state IDLE/RUN machine that emits
// single-cycle start/stop command pulses to a downstream counter stage.
// The FSM state is visible on `running`, which is 1 exactly when in RUN.
module btn_start_stop_ctrl #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_stop,
    output logic start,
    output logic stop,
    output logic running
);

    // Last counter value before the stable level is allowed to flip.
    localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // Bit 0 carries the start button, bit 1 the stop button.
    logic [1:0]  btn_raw;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  stable;
    logic [1:0]  stable_d;
    logic [15:0] db_cnt [2];
    logic [1:0]  press;
    logic        start_evt;
    logic        stop_evt;

    assign btn_raw   = {btn_stop, btn_start};
    // Press = rising edge of the debounced level; releases are ignored.
    assign press     = stable & ~stable_d;
    assign start_evt = press[0];
    assign stop_evt  = press[1];

    // Two-flop synchronizer for both asynchronous buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: the stable level only follows the synchronized input after
    // DB_CYCLES consecutive samples that disagree with it; any agreeing
    // sample restarts the count, so short glitches are filtered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // One-cycle delayed copy of the debounced levels for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    // IDLE/RUN machine with registered pulse and level outputs. Only the
    // press relevant to the current state is honoured, which also settles
    // simultaneous presses (start wins in IDLE, stop wins in RUN).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start   <= 1'b0;
            stop    <= 1'b0;
            running <= 1'b0;
        end else begin
            start <= 1'b0;
            stop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_evt) begin
                        start   <= 1'b1;
                        running <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (stop_evt) begin
                        stop    <= 1'b1;
                        running <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    running <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_start_stop_ctrl.sv
// Bench for btn_start_stop_ctrl: directed button scenarios push the expected
// pulses (kind + cycle) into a queue; a monitor pops and compares whenever
// the DUT shows a start or stop pulse.
module tb_btn_start_stop_ctrl;

  localparam int DB = 4;
  // Raw rise at the negedge with cycle count c -> pulse seen at c + DB + 3.
  localparam int LAT = DB + 3;

  logic clk;
  logic reset;
  logic btn_start;
  logic btn_stop;
  logic start;
  logic stop;
  logic running;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected pulse: bit 31 = stop, bit 30 = start, bits 29:0 = cycle.
  logic [31:0] exp_q[$];

  btn_start_stop_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .start     (start),
    .stop      (stop),
    .running   (running)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input bit is_stop, input int at);
    exp_q.push_back({is_stop, ~is_stop, 30'(at)});
  endtask

  // Raise the selected buttons together, hold, release, then settle.
  // exp_kind: 0 = start pulse expected, 1 = stop pulse expected, -1 = none.
  task automatic drive(input bit do_start, input bit do_stop, input int hold, input int exp_kind);
    @(negedge clk);
    if (exp_kind == 0) expect_pulse(1'b0, cyc + LAT);
    if (exp_kind == 1) expect_pulse(1'b1, cyc + LAT);
    btn_start = do_start;
    btn_stop  = do_stop;
    repeat (hold) @(negedge clk);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (start || stop) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse start=%0b stop=%0b required=none (cyc=%0d)", start, stop, cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pulse", {stop, start, 30'(cyc)}, e);
      end
    end
  end

  initial begin
    int c;
    int r;
    int guard;
    logic [8:0] bouncy;
    bouncy = 9'b111101101; // applied LSB first: 1,0,1,1,0,1,1,1,1

    reset = 1'b0;
    btn_start = 1'b0;
    btn_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_start", {31'd0, start}, 32'd0);
    check("reset_stop", {31'd0, stop}, 32'd0);
    check("reset_running", {31'd0, running}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Start press with latency check: pulse between edges 6 and 7.
    @(negedge clk);
    c = cyc;
    expect_pulse(1'b0, c + LAT);
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    check("running_before_start", {31'd0, running}, 32'd0);
    @(negedge clk);
    check("running_after_start", {31'd0, running}, 32'd1);
    repeat (6) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);

    // 3-cycle stop glitch in RUN is filtered.
    drive(1'b0, 1'b1, 3, -1);
    check("running_after_glitch", {31'd0, running}, 32'd1);

    // Stop held 10 cycles: one pulse, back to IDLE.
    drive(1'b0, 1'b1, 10, 1);
    check("running_after_stop", {31'd0, running}, 32'd0);

    // Stop press in IDLE is ignored.
    drive(1'b0, 1'b1, 10, -1);
    check("running_stop_in_idle", {31'd0, running}, 32'd0);

    // Simultaneous presses: start wins in IDLE, stop wins in RUN.
    drive(1'b1, 1'b1, 10, 0);
    check("running_both_idle", {31'd0, running}, 32'd1);
    drive(1'b1, 1'b1, 10, 1);
    check("running_both_run", {31'd0, running}, 32'd0);

    // Enter RUN, then reset during a start debounce at counter=2.
    drive(1'b1, 1'b0, 10, 0);
    @(negedge clk);
    btn_start = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_running", {31'd0, running}, 32'd0);
    check("async_reset_start", {31'd0, start}, 32'd0);
    check("async_reset_stop", {31'd0, stop}, 32'd0);
    repeat (3) @(negedge clk);
    r = cyc;
    expect_pulse(1'b0, r + LAT);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
    check("running_after_reset_press", {31'd0, running}, 32'd1);

    // Back to IDLE, then a bouncy start press.
    drive(1'b0, 1'b1, 10, 1);
    check("running_before_bouncy", {31'd0, running}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        c = cyc;
        expect_pulse(1'b0, c + 12);
      end
      btn_start = bouncy[i];
    end
    repeat (15) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
    check("running_after_bouncy", {31'd0, running}, 32'd1);

    // final report
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
